// File: rtl/line_doubler_pkg.sv
// line_doubler shared types and constants.
// Sizes, pixel bundle and scanline dimming helper.
package line_doubler_pkg;

    localparam int MAX_W = 512;
    localparam int CW    = 6;
    localparam int X_W   = 10;
    localparam int AW    = $clog2(MAX_W);

    localparam logic [X_W-1:0] X_MAX   = '1;
    localparam logic [X_W-1:0] X_LIM   = X_W'(MAX_W);
    localparam logic [X_W:0]   LEN_RST = (X_W + 1)'(MAX_W);

    typedef struct packed {
        logic [CW-1:0] r;
        logic [CW-1:0] g;
        logic [CW-1:0] b;
    } rgb_t;

    typedef enum logic [1:0] {
        SL_OFF,
        SL_75,
        SL_50,
        SL_25
    } scanline_mode_t;

    // Only the repeated (odd) output line is ever dimmed.
    function automatic logic [CW-1:0] dim_ch(
        input logic [CW-1:0] c,
        input scanline_mode_t m,
        input logic odd
    );
        logic [CW-1:0] d;
        d = c;
        if (odd) begin
            unique case (m)
                SL_75:   d = (c >> 1) + (c >> 2);
                SL_50:   d = c >> 1;
                SL_25:   d = c >> 2;
                default: d = c;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/line_doubler_if.sv
// line_doubler video bus.
// master drives the 8 MHz stream, slave returns the doubled one.
interface line_doubler_if;
    import line_doubler_pkg::*;

    logic          ce_in;
    logic          hs_in;
    logic          vs_in;
    logic [CW-1:0] r_in;
    logic [CW-1:0] g_in;
    logic [CW-1:0] b_in;
    logic [1:0]    scanlines;

    logic          hs_out;
    logic          vs_out;
    logic [CW-1:0] r_out;
    logic [CW-1:0] g_out;
    logic [CW-1:0] b_out;

    modport master (
        output ce_in, hs_in, vs_in,
        output r_in, g_in, b_in, scanlines,
        input  hs_out, vs_out,
        input  r_out, g_out, b_out
    );

    modport slave (
        input  ce_in, hs_in, vs_in,
        input  r_in, g_in, b_in, scanlines,
        output hs_out, vs_out,
        output r_out, g_out, b_out
    );

endinterface

// File: rtl/line_doubler_line_buf.sv
// line_buf: two-bank pixel line store.
// Simple dual-port RAM with registered read data, no reset.
module line_buf
    import line_doubler_pkg::*;
(
    input  logic        clk,
    input  logic        we,
    input  logic [AW:0] waddr,
    input  rgb_t        wdata,
    input  logic [AW:0] raddr,
    output rgb_t        q
);

    logic [3*CW-1:0] mem [0:2*MAX_W-1];

    // Write port: one pixel per input strobe.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read port: one clock latency.
    always_ff @(posedge clk) begin
        q <= rgb_t'(mem[raddr]);
    end

endmodule

// File: rtl/line_doubler.sv
// line_doubler: 15.6 kHz to 31.25 kHz scan doubler.
// Each input line is replayed twice from a ping-pong buffer.
module line_doubler
    import line_doubler_pkg::*;
(
    input  logic          clk_pix,
    input  logic          reset,
    line_doubler_if.slave vid
);

    logic [X_W-1:0] in_x;
    logic [X_W-1:0] hs_len;
    logic [X_W-1:0] hs_last;
    logic [X_W:0]   line_len;
    logic           hs_prev;
    logic           wr_bank;
    logic           vs_lat;
    logic           line_start;
    logic           hs_rise;

    logic [X_W-1:0] wr_x;
    logic           wr_bk;
    logic           we;
    rgb_t           wdata;

    logic [X_W-1:0] out_x;
    logic [X_W:0]   out_len;
    logic [X_W-1:0] hs_len_o;
    logic           out_line;
    logic           vs_src;
    logic           rd_bank;
    logic           ls_seen;
    logic           valid;

    logic           hs0;
    logic           blank0;
    logic           hs1;
    logic           vs1;
    logic           odd1;
    logic           blank1;
    rgb_t           rd_q;

    scanline_mode_t sl_mode;

    assign hs_rise = vid.ce_in && vid.hs_in && !hs_prev;
    assign sl_mode = scanline_mode_t'(vid.scanlines);
    assign wdata   = '{r: vid.r_in, g: vid.g_in, b: vid.b_in};

    // Index of the pixel being sampled now; also the next in_x.
    always_comb begin
        wr_x  = (in_x == X_MAX) ? in_x : in_x + 1'b1;
        wr_bk = wr_bank;
        if (hs_rise) begin
            wr_x  = '0;
            wr_bk = ~wr_bank;
        end
        we = vid.ce_in && !reset && (wr_x < X_LIM);
    end

    // Input side: measure line and hsync, flip banks on hsync rise.
    always_ff @(posedge clk_pix) begin
        if (reset) begin
            in_x       <= '0;
            hs_len     <= '0;
            hs_last    <= '0;
            line_len   <= LEN_RST;
            hs_prev    <= 1'b0;
            wr_bank    <= 1'b0;
            vs_lat     <= 1'b0;
            line_start <= 1'b0;
        end else begin
            line_start <= hs_rise;
            if (vid.ce_in) begin
                hs_prev <= vid.hs_in;
                in_x    <= wr_x;
                if (hs_rise) begin
                    line_len <= {1'b0, in_x} + 1'b1;
                    wr_bank  <= ~wr_bank;
                    vs_lat   <= vid.vs_in;
                    hs_last  <= hs_len;
                    hs_len   <= X_W'(1);
                end else if (vid.hs_in && hs_len != X_MAX) begin
                    hs_len <= hs_len + 1'b1;
                end
            end
        end
    end

    line_buf u_buf (
        .clk   (clk_pix),
        .we    (we),
        .waddr ({wr_bk, wr_x[AW-1:0]}),
        .wdata (wdata),
        .raddr ({rd_bank, out_x[AW-1:0]}),
        .q     (rd_q)
    );

    // Output timebase: two lines of line_len clocks per input line.
    always_ff @(posedge clk_pix) begin
        if (reset) begin
            out_x    <= '0;
            out_len  <= LEN_RST;
            hs_len_o <= '0;
            out_line <= 1'b0;
            vs_src   <= 1'b0;
            rd_bank  <= 1'b0;
            ls_seen  <= 1'b0;
            valid    <= 1'b0;
        end else if (line_start) begin
            out_x    <= '0;
            out_len  <= line_len;
            hs_len_o <= hs_last;
            out_line <= 1'b0;
            vs_src   <= vs_lat;
            rd_bank  <= ~wr_bank;
            ls_seen  <= 1'b1;
            if (ls_seen) valid <= 1'b1;
        end else if ({1'b0, out_x} == out_len - 1'b1) begin
            out_x    <= '0;
            out_line <= 1'b1;
        end else begin
            out_x <= out_x + 1'b1;
        end
    end

    assign hs0    = out_x < hs_len_o;
    assign blank0 = !valid || (out_x >= X_LIM) ||
                    ({1'b0, out_x} >= out_len);

    // Delay sync and blanking to line up with RAM read data.
    always_ff @(posedge clk_pix) begin
        if (reset) begin
            hs1    <= 1'b0;
            vs1    <= 1'b0;
            odd1   <= 1'b0;
            blank1 <= 1'b1;
        end else begin
            hs1    <= hs0;
            vs1    <= vs_src;
            odd1   <= out_line;
            blank1 <= blank0;
        end
    end

    // Output register: blanking and scanline dimming.
    always_ff @(posedge clk_pix) begin
        if (reset) begin
            vid.hs_out <= 1'b0;
            vid.vs_out <= 1'b0;
            vid.r_out  <= '0;
            vid.g_out  <= '0;
            vid.b_out  <= '0;
        end else begin
            vid.hs_out <= hs1;
            vid.vs_out <= vs1;
            if (blank1) begin
                vid.r_out <= '0;
                vid.g_out <= '0;
                vid.b_out <= '0;
            end else begin
                vid.r_out <= dim_ch(rd_q.r, sl_mode, odd1);
                vid.g_out <= dim_ch(rd_q.g, sl_mode, odd1);
                vid.b_out <= dim_ch(rd_q.b, sl_mode, odd1);
            end
        end
    end

endmodule
